// File: rtl/hazard_forward_ctrl_if.sv
// Bundle of ID-stage decode fields and hazard-control outputs shared between
// the decode stage (master) and the hazard/forwarding controller (slave).
interface hazard_forward_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  flush;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
    logic                  pc_write_en;
    logic                  ifid_write_en;
    logic                  idex_bubble;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_mem_read, flush,
        input  fwd_a_sel, fwd_b_sel, pc_write_en, ifid_write_en,
               idex_bubble, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_mem_read, flush,
        output fwd_a_sel, fwd_b_sel, pc_write_en, ifid_write_en,
               idex_bubble, stall_count
    );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Load-use stall and ALU operand forwarding control for the 5-stage core.
// Tracks rd/reg_write/mem_read of the EX, MEM and WB instructions.
module hazard_forward_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic arst_n,
    hazard_forward_ctrl_if.slave hif
);
    localparam logic [REG_ADDR_W-1:0] X0       = {REG_ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]            SEL_RF   = 2'b00;
    localparam logic [1:0]            SEL_EXM  = 2'b01;
    localparam logic [1:0]            SEL_MWB  = 2'b10;

    logic [REG_ADDR_W-1:0] ex_rd_r, mem_rd_r, wb_rd_r;
    logic                  ex_reg_write_r, mem_reg_write_r, wb_reg_write_r;
    logic                  ex_mem_read_r, mem_mem_read_r, wb_mem_read_r;
    logic [1:0]            fwd_a_r, fwd_b_r;
    logic [CNT_W-1:0]      stall_count_r;

    logic       lu_s, stall_s, bubble_s, enter_s;
    logic [1:0] sel_a_s, sel_b_s;
    logic       unused_s;

    // Younger producer (about to move into MEM) wins over the older one; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel_f(
        input logic                  enter,
        input logic                  use_rs,
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  ex_rw,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic                  mem_rw,
        input logic [REG_ADDR_W-1:0] mem_rd
    );
        logic [1:0] sel;
        if (!enter || !use_rs) begin
            sel = SEL_RF;
        end else if (ex_rw && (ex_rd != X0) && (ex_rd == rs)) begin
            sel = SEL_EXM;
        end else if (mem_rw && (mem_rd != X0) && (mem_rd == rs)) begin
            sel = SEL_MWB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    // Hazard detection, pipeline enables and next forwarding selects.
    always_comb begin
        lu_s = hif.id_valid && ex_mem_read_r && (ex_rd_r != X0) &&
               ((hif.id_use_rs1 && (hif.id_rs1 == ex_rd_r)) ||
                (hif.id_use_rs2 && (hif.id_rs2 == ex_rd_r)));
        stall_s  = lu_s && !hif.flush;
        bubble_s = stall_s || hif.flush;
        enter_s  = hif.id_valid && !bubble_s;
        sel_a_s  = fwd_sel_f(enter_s, hif.id_use_rs1, hif.id_rs1,
                             ex_reg_write_r, ex_rd_r, mem_reg_write_r, mem_rd_r);
        sel_b_s  = fwd_sel_f(enter_s, hif.id_use_rs2, hif.id_rs2,
                             ex_reg_write_r, ex_rd_r, mem_reg_write_r, mem_rd_r);
    end

    // Tracker shift, registered selects and saturating stall counter.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ex_rd_r         <= X0;
            ex_reg_write_r  <= 1'b0;
            ex_mem_read_r   <= 1'b0;
            mem_rd_r        <= X0;
            mem_reg_write_r <= 1'b0;
            mem_mem_read_r  <= 1'b0;
            wb_rd_r         <= X0;
            wb_reg_write_r  <= 1'b0;
            wb_mem_read_r   <= 1'b0;
            fwd_a_r         <= SEL_RF;
            fwd_b_r         <= SEL_RF;
            stall_count_r   <= {CNT_W{1'b0}};
        end else begin
            if (enter_s) begin
                ex_rd_r        <= hif.id_rd;
                ex_reg_write_r <= hif.id_reg_write;
                ex_mem_read_r  <= hif.id_mem_read;
            end else begin
                ex_rd_r        <= X0;
                ex_reg_write_r <= 1'b0;
                ex_mem_read_r  <= 1'b0;
            end
            mem_rd_r        <= ex_rd_r;
            mem_reg_write_r <= ex_reg_write_r;
            mem_mem_read_r  <= ex_mem_read_r;
            wb_rd_r         <= mem_rd_r;
            wb_reg_write_r  <= mem_reg_write_r;
            wb_mem_read_r   <= mem_mem_read_r;
            fwd_a_r         <= sel_a_s;
            fwd_b_r         <= sel_b_s;
            if (stall_s && (stall_count_r != CNT_MAX)) begin
                stall_count_r <= stall_count_r + CNT_ONE;
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

    // WB results reach ID through register-file write-through, so the WB tracker has no consumer here.
    assign unused_s = ^{wb_rd_r, wb_reg_write_r, wb_mem_read_r, mem_mem_read_r};

    assign hif.fwd_a_sel     = fwd_a_r;
    assign hif.fwd_b_sel     = fwd_b_r;
    assign hif.stall_count   = stall_count_r;
    assign hif.pc_write_en   = !stall_s;
    assign hif.ifid_write_en = !stall_s;
    assign hif.idex_bubble   = bubble_s;
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed-vector bench for hazard_forward_ctrl; a second narrow-counter
// instance exercises stall counter saturation in a short run.
module tb_hazard_forward_ctrl;
    logic clk;
    logic arst_n;
    int   tests_run;
    int   tests_failed;

    hazard_forward_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) hif ();
    hazard_forward_ctrl_if #(.REG_ADDR_W(5), .CNT_W(6))  hif_sat ();

    hazard_forward_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .arst_n(arst_n), .hif(hif)
    );
    hazard_forward_ctrl #(.REG_ADDR_W(5), .CNT_W(6)) dut_sat (
        .clk(clk), .arst_n(arst_n), .hif(hif_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic fl);
        hif.id_valid     = v;
        hif.id_rs1       = rs1;
        hif.id_use_rs1   = u1;
        hif.id_rs2       = rs2;
        hif.id_use_rs2   = u2;
        hif.id_rd        = rd;
        hif.id_reg_write = rw;
        hif.id_mem_read  = mr;
        hif.flush        = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        arst_n       = 1'b0;
        hif_sat.id_valid     = 1'b0;
        hif_sat.id_rs1       = 5'd0;
        hif_sat.id_use_rs1   = 1'b0;
        hif_sat.id_rs2       = 5'd0;
        hif_sat.id_use_rs2   = 1'b0;
        hif_sat.id_rd        = 5'd0;
        hif_sat.id_reg_write = 1'b0;
        hif_sat.id_mem_read  = 1'b0;
        hif_sat.flush        = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

        // reset state
        check_eq("rst_fwd_a", 32'(hif.fwd_a_sel), 32'd0);
        check_eq("rst_fwd_b", 32'(hif.fwd_b_sel), 32'd0);
        check_eq("rst_count", 32'(hif.stall_count), 32'd0);
        check_eq("rst_pc_we", 32'(hif.pc_write_en), 32'd1);
        check_eq("rst_ifid_we", 32'(hif.ifid_write_en), 32'd1);
        check_eq("rst_bubble", 32'(hif.idex_bubble), 32'd0);
        @(posedge clk);
        #2 arst_n = 1'b1;
        idle(2);

        // add x3 ; sub x4,x3,x5 -> A from EX/MEM
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        check_eq("alu_nostall_pc_we", 32'(hif.pc_write_en), 32'd1);
        tick();
        check_eq("alu_fwd_a", 32'(hif.fwd_a_sel), 32'd1);
        check_eq("alu_fwd_b", 32'(hif.fwd_b_sel), 32'd0);
        idle(3);

        // add x3 ; nop ; or x6,x5,x3 -> B from MEM/WB
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        idle(1);
        drive(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        tick();
        check_eq("gap_fwd_a", 32'(hif.fwd_a_sel), 32'd0);
        check_eq("gap_fwd_b", 32'(hif.fwd_b_sel), 32'd2);
        idle(3);

        // add x3 ; add x3 ; or x6,x5,x3 -> younger producer wins
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        tick();
        check_eq("prio_fwd_b", 32'(hif.fwd_b_sel), 32'd1);
        idle(3);

        // lw x7 ; add x8,x7,x7 -> one stall, then both from MEM/WB
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        check_eq("lu_pc_we", 32'(hif.pc_write_en), 32'd0);
        check_eq("lu_ifid_we", 32'(hif.ifid_write_en), 32'd0);
        check_eq("lu_bubble", 32'(hif.idex_bubble), 32'd1);
        tick();
        check_eq("lu_count", 32'(hif.stall_count), 32'd1);
        check_eq("lu_bubble_sel", 32'(hif.fwd_a_sel), 32'd0);
        check_eq("lu_release_pc_we", 32'(hif.pc_write_en), 32'd1);
        check_eq("lu_release_bubble", 32'(hif.idex_bubble), 32'd0);
        tick();
        check_eq("lu_fwd_a", 32'(hif.fwd_a_sel), 32'd2);
        check_eq("lu_fwd_b", 32'(hif.fwd_b_sel), 32'd2);
        check_eq("lu_count_hold", 32'(hif.stall_count), 32'd1);
        idle(3);

        // x0 never stalls nor forwards
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
        check_eq("x0_lw_pc_we", 32'(hif.pc_write_en), 32'd1);
        check_eq("x0_lw_bubble", 32'(hif.idex_bubble), 32'd0);
        tick();
        check_eq("x0_lw_fwd_a", 32'(hif.fwd_a_sel), 32'd0);
        check_eq("x0_lw_fwd_b", 32'(hif.fwd_b_sel), 32'd0);
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
        tick();
        check_eq("x0_add_fwd_a", 32'(hif.fwd_a_sel), 32'd0);
        check_eq("x0_add_fwd_b", 32'(hif.fwd_b_sel), 32'd0);
        idle(3);

        // flush wins over load-use
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
        check_eq("flush_pc_we", 32'(hif.pc_write_en), 32'd1);
        check_eq("flush_bubble", 32'(hif.idex_bubble), 32'd1);
        tick();
        check_eq("flush_count", 32'(hif.stall_count), 32'd1);
        check_eq("flush_fwd_a", 32'(hif.fwd_a_sel), 32'd0);
        idle(3);

        // back-to-back loads, consumer two behind -> no stall, MEM/WB forward
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd7, 1'b1, 5'd2, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
        check_eq("b2b_pc_we", 32'(hif.pc_write_en), 32'd1);
        tick();
        check_eq("b2b_fwd_a", 32'(hif.fwd_a_sel), 32'd2);
        idle(3);

        // reset pulsed during a stall
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        check_eq("rststall_pre_pc_we", 32'(hif.pc_write_en), 32'd0);
        arst_n = 1'b0;
        #1;
        check_eq("rststall_count", 32'(hif.stall_count), 32'd0);
        check_eq("rststall_fwd_a", 32'(hif.fwd_a_sel), 32'd0);
        check_eq("rststall_fwd_b", 32'(hif.fwd_b_sel), 32'd0);
        check_eq("rststall_pc_we", 32'(hif.pc_write_en), 32'd1);
        check_eq("rststall_ifid_we", 32'(hif.ifid_write_en), 32'd1);
        check_eq("rststall_bubble", 32'(hif.idex_bubble), 32'd0);
        arst_n = 1'b1;
        idle(1);
        check_eq("rststall_count_after", 32'(hif.stall_count), 32'd0);

        // saturation on the 6-bit counter: lw x7,(x7) repeated stalls every other cycle
        hif_sat.id_valid     = 1'b1;
        hif_sat.id_rs1       = 5'd7;
        hif_sat.id_use_rs1   = 1'b1;
        hif_sat.id_rd        = 5'd7;
        hif_sat.id_reg_write = 1'b1;
        hif_sat.id_mem_read  = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check_eq("sat_count_mid", 32'(hif_sat.stall_count), 32'd10);
        for (int i = 0; i < 120; i++) tick();
        check_eq("sat_count_max", 32'(hif_sat.stall_count), 32'd63);
        hif_sat.id_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
